// File: rtl/mux_in_debounce.sv
// mux_in_debounce: synchronises, debounces and conditions the raw a/b/sel pad inputs for the 2:1 mux.
// A new level is accepted only after STABLE_CYCLES consecutive mismatching samples; sel can act as a toggle button.
module mux_in_debounce #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] raw_in,
  input  logic       sel_mode,
  output logic       a_o,
  output logic       b_o,
  output logic       sel_o,
  output logic [2:0] chg_pulse
);
  typedef enum logic {STABLE, CHECK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [2:0] sync1_q, sync2_q, deb_q, deb_d, commit;
  logic       tog_q, tog_d;
  for (genvar c = 0; c < 3; c++) begin : g_ch
    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             diff;
    assign diff = sync2_q[c] ^ deb_q[c];
    // With a one-cycle threshold the very first mismatch seen in STABLE commits.
    assign commit[c] = diff && (st_q == STABLE ? STABLE_CYCLES == 1 : cnt_q == LAST);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st_q  <= STABLE;
        cnt_q <= '0;
      end else if (!diff || commit[c]) begin
        st_q  <= STABLE;
        cnt_q <= '0;
      end else begin
        st_q  <= CHECK;
        cnt_q <= cnt_q + CNT_W'(1);
      end
  end
  assign deb_d = deb_q ^ commit;
  assign tog_d = tog_q ^ (commit[2] & deb_d[2]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      tog_q     <= 1'b0;
      chg_pulse <= '0;
      sel_o     <= 1'b0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      tog_q     <= tog_d;
      chg_pulse <= commit;
      sel_o     <= sel_mode ? tog_q : deb_q[2];
    end
  assign a_o = deb_q[0];
  assign b_o = deb_q[1];
endmodule

// File: tb/tb_mux_in_debounce.sv
// tb_mux_in_debounce: random pad activity against a sample-window reference model, checked through a scoreboard queue.
module tb_mux_in_debounce;
  localparam int S = 8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw_in = '0;
  logic       sel_mode = 1'b0;
  logic       a_o, b_o, sel_o;
  logic [2:0] chg_pulse;
  int checks = 0;
  int errors = 0;

  mux_in_debounce #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .sel_mode(sel_mode),
    .a_o(a_o), .b_o(b_o), .sel_o(sel_o), .chg_pulse(chg_pulse)
  );

  always #5 clk = ~clk;

  // Model: a channel commits when its last S synchronised samples all disagree with the debounced level.
  logic [2:0] hist[$];
  logic [2:0] m_deb, m_pulse;
  logic       m_tog, m_sel;
  logic [5:0] exp_q[$];

  task automatic model_reset();
    hist.delete();
    repeat (S + 2) hist.push_back(3'b000);
    m_deb = '0; m_pulse = '0; m_tog = 1'b0; m_sel = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic [2:0] r, input logic mode);
    logic [2:0] cm;
    logic       nsel;
    raw_in = r;
    sel_mode = mode;
    nsel = mode ? m_tog : m_deb[2];
    for (int ch = 0; ch < 3; ch++) begin
      cm[ch] = 1'b1;
      for (int k = 0; k < S; k++)
        if (hist[hist.size() - 2 - k][ch] == m_deb[ch]) cm[ch] = 1'b0;
    end
    m_deb = m_deb ^ cm;
    if (cm[2] && m_deb[2]) m_tog = ~m_tog;
    m_pulse = cm;
    m_sel = nsel;
    hist.push_back(r);
    void'(hist.pop_front());
    exp_q.push_back({m_deb[0], m_deb[1], m_sel, m_pulse});
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({a_o, b_o, sel_o, chg_pulse} !== 6'b0) begin
      errors++;
      $display("FAIL %s got %b expected 000000", name, {a_o, b_o, sel_o, chg_pulse});
    end
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({a_o, b_o, sel_o, chg_pulse} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got {a,b,sel,pulse}=%b expected %b", $time, {a_o, b_o, sel_o, chg_pulse}, e);
        end
      end
    end
  end

  initial begin : driver
    int n;
    logic [2:0] r;
    logic mode;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset_values");
    @(negedge clk);
    rst = 1'b0;
    step(3'b011, 1'b0);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if (chg_pulse != 3'b000 || n == 20) break;
      @(negedge clk);
      step(3'b011, 1'b0);
    end
    checks++;
    if (n != S + 2 || chg_pulse !== 3'b011 || a_o !== 1'b1 || b_o !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous_latency got edges=%0d pulse=%b a=%b b=%b expected edges=%0d pulse=011 a=1 b=1", n, chg_pulse, a_o, b_o, S + 2);
    end
    r = 3'b011;
    mode = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 11) == 0) r[ch] = ~r[ch];
      if ($urandom_range(0, 150) == 0) mode = ~mode;
      step(r, mode);
      if (cyc % 900 == 450) begin
        #2 rst = 1'b1;
        exp_q.delete();
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1 check_zero("reset_held");
      end
    end
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_in_debounce.md
# mux_in_debounce

Input-conditioning stage that sits directly upstream of the 2:1 mux datapath. It takes the three raw pad inputs (a, b, sel) from ui_in[2:0] and synchronises each one into the clk domain. It debounces each input and presents clean, registered a/b/sel levels to the mux. Optionally, the sel button acts as a push-to-toggle control instead of a level.

## Interface

Parameters:
- STABLE_CYCLES, 8, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates; legal range 1..2^CNT_W-1
- CNT_W, 4, debounce counter width per channel

Ports:
- clk  input  1  single clock
- rst  input  1  asynchronous, active-high reset
- raw_in  input  3  unsynchronised pad inputs; [0]=a, [1]=b, [2]=sel
- sel_mode  input  1  0 = sel_o follows debounced sel level; 1 = sel_o toggles on each debounced rising edge of raw_in[2]
- a_o  output  1  debounced a (registered)
- b_o  output  1  debounced b (registered)
- sel_o  output  1  select to mux (registered)
- chg_pulse  output  3  one-cycle pulse per channel when that channel's debounced value changes

## Operation

- Per channel: 2-FF synchroniser sync1 -> sync2, debounce register deb, counter cnt[CNT_W-1:0], FSM {STABLE, CHECK}.
- STABLE, sync2 == deb: cnt held at 0.
- STABLE, sync2 != deb: go to CHECK, cnt <= 1. If STABLE_CYCLES == 1, instead update immediately per the commit rule.
- CHECK, sync2 == deb: glitch rejected; go to STABLE, cnt <= 0, deb unchanged, no pulse.
- CHECK, sync2 != deb, cnt+1 < STABLE_CYCLES: cnt <= cnt+1.
- CHECK, sync2 != deb, cnt+1 == STABLE_CYCLES (commit rule): deb <= sync2, cnt <= 0, go to STABLE, chg_pulse[ch] <= 1 for exactly one cycle.
- Counter never wraps; it saturates by construction at STABLE_CYCLES-1 before commit.
- a_o = deb[0], b_o = deb[1] (deb is a register, so no extra stage).
- Toggle register tog: flips on the cycle chg_pulse[2] is asserted with deb[2] newly 1. A falling commit does not flip it.
- sel_o registered each cycle: sel_o <= sel_mode ? tog : deb[2]. A sel_mode change takes effect at the next edge. tog is retained across mode changes.
- Channels are fully independent; simultaneous commits on several channels assert several chg_pulse bits in the same cycle.
- Reset (async assert, any time, including mid-CHECK): sync1, sync2, deb, cnt, tog, sel_o and chg_pulse all go to 0; FSM goes to STABLE. Any in-progress debounce is discarded.

## Timing

- Reset values: a_o=0, b_o=0, sel_o=0, chg_pulse=3'b000.
- Raw edge set up before clock edge E1: sync2 shows it after E2. The first mismatch is counted at E3. deb/a_o/b_o update and chg_pulse fires at edge E(2+STABLE_CYCLES).
- Level-mode sel_o lags deb[2] by one cycle, giving total latency 3+STABLE_CYCLES.
- Toggle-mode sel_o changes one cycle after the committing rising edge of deb[2].
- A pulse of raw input that yields fewer than STABLE_CYCLES consecutive mismatched sync2 samples never changes deb.
- Reset release is synchronous to the next clk edge; the first sample occurs at the first edge after deassertion.

## Test plan

- Clean step, STABLE_CYCLES=8: raw_in[0] 0->1 held, applied before E1 -> a_o=1 and chg_pulse=3'b001 for one cycle at E10; no further pulses.
- Glitch rejection: raw_in[1] high for 7 sync2 cycles, then low -> b_o stays 0, chg_pulse[1] never asserts, FSM returns to STABLE with cnt=0.
- Toggle mode: sel_mode=1, three clean press/release cycles on raw_in[2] -> sel_o sequence 1,0,1, one change per press; releases produce chg_pulse[2] but no sel_o change.
- Mode switch: sel_mode=1 with tog=1 and deb[2]=0; set sel_mode=0 -> sel_o=0 one edge later; return to 1 -> sel_o=1 (tog retained).
- Reset mid-debounce: assert rst while channel 0 is at cnt=5 -> all outputs 0 immediately; after release, raw_in[0]=1 needs the full 2+8 edges to commit.
- Simultaneous: raw_in 3'b000 -> 3'b011 on the same edge -> a_o and b_o rise together and chg_pulse=3'b011 in a single cycle.
